// File: rtl/dec_sample_fifo_if.sv
// Sample-FIFO bus: producer strobe/data in, valid/ready drain out, status flags.
interface dec_sample_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned FW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] sum_in;
  logic             sum_stb;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    fill;
  logic             overflow;
  logic             ovf_clr;

  // FIFO side
  modport slave (
    input  sum_in, sum_stb, out_ready, ovf_clr,
    output out_data, out_valid, fill, overflow
  );

  // Producer/consumer side
  modport master (
    output sum_in, sum_stb, out_ready, ovf_clr,
    input  out_data, out_valid, fill, overflow
  );
endinterface

// File: rtl/dec_sample_fifo.sv
// Captures strobed decimated sums, right-shifts them, and buffers them in a
// first-word-fall-through FIFO drained by valid/ready. Drops on full are
// flagged by a sticky overflow bit.
module dec_sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  dec_sample_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             full, push, pop, drop;

  // Handshake decode and next-state for pointers, occupancy and flags
  always_comb begin
    full     = (fill_q == FW'(DEPTH));
    pop      = valid_q & bus.out_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    push     = bus.sum_stb & (~full | pop);
    drop     = bus.sum_stb & full & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      fill_d = fill_q + FW'(1);
    else if (pop && !push) fill_d = fill_q - FW'(1);
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
    valid_d  = (fill_d != '0);
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; contents need no reset since valid gates the output
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.sum_in >> SHIFT;
  end

  // Head-of-FIFO output, forced to zero when empty
  always_comb begin
    bus.out_data  = valid_q ? mem_q[rd_ptr_q] : '0;
    bus.out_valid = valid_q;
    bus.fill      = fill_q;
    bus.overflow  = ovf_q;
  end
endmodule

// File: tb/tb_dec_sample_fifo.sv
// Directed bench for dec_sample_fifo: one SHIFT=0 and one SHIFT=2 instance.
module tb_dec_sample_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntotal = 0;

  always #5 clk = ~clk;

  dec_sample_fifo_if #(.WIDTH(8), .DEPTH(4)) ifa ();
  dec_sample_fifo_if #(.WIDTH(8), .DEPTH(4)) ifb ();

  dec_sample_fifo #(.WIDTH(8), .DEPTH(4), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  dec_sample_fifo #(.WIDTH(8), .DEPTH(4), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    ifa.sum_in = '0; ifa.sum_stb = 1'b0; ifa.out_ready = 1'b0; ifa.ovf_clr = 1'b0;
    ifb.sum_in = '0; ifb.sum_stb = 1'b0; ifb.out_ready = 1'b0; ifb.ovf_clr = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_fill", int'(ifa.fill), 0);
    chk("rst_valid", int'(ifa.out_valid), 0);
    chk("rst_data", int'(ifa.out_data), 0);
    chk("rst_ovf", int'(ifa.overflow), 0);

    // Shifted build: FF>>2=3F, 13>>2=04
    ifb.sum_stb = 1'b1; ifb.sum_in = 8'hFF; tick();
    ifb.sum_in = 8'h13; tick();
    ifb.sum_stb = 1'b0;
    chk("sh_fill2", int'(ifb.fill), 2);
    chk("sh_head0", int'(ifb.out_data), 'h3F);
    ifb.out_ready = 1'b1; tick();
    chk("sh_head1", int'(ifb.out_data), 'h04);
    tick();
    ifb.out_ready = 1'b0;
    chk("sh_valid_end", int'(ifb.out_valid), 0);
    chk("sh_fill_end", int'(ifb.fill), 0);
    chk("sh_data_end", int'(ifb.out_data), 0);

    // Single push latency
    ifa.sum_stb = 1'b1; ifa.sum_in = 8'h5A; tick();
    ifa.sum_stb = 1'b0;
    chk("t1_valid", int'(ifa.out_valid), 1);
    chk("t1_data", int'(ifa.out_data), 'h5A);
    chk("t1_fill", int'(ifa.fill), 1);
    ifa.out_ready = 1'b1; tick();
    chk("t1_drain_fill", int'(ifa.fill), 0);
    chk("t1_drain_valid", int'(ifa.out_valid), 0);
    // Ready while empty must not pop
    tick();
    ifa.out_ready = 1'b0;
    chk("empty_rdy_fill", int'(ifa.fill), 0);

    // Fill to capacity then overflow with sample 5
    for (int i = 1; i <= 4; i++) begin
      ifa.sum_stb = 1'b1; ifa.sum_in = 8'(i); tick();
    end
    chk("t3_fill4", int'(ifa.fill), 4);
    chk("t3_ovf_pre", int'(ifa.overflow), 0);
    ifa.sum_in = 8'd5; tick();
    ifa.sum_stb = 1'b0;
    chk("t3_fill_full", int'(ifa.fill), 4);
    chk("t3_ovf", int'(ifa.overflow), 1);
    tick();
    chk("t3_hold_data", int'(ifa.out_data), 1);

    // Set beats clear; clear alone then takes effect
    ifa.sum_stb = 1'b1; ifa.sum_in = 8'h77; ifa.ovf_clr = 1'b1; tick();
    ifa.sum_stb = 1'b0;
    chk("t5_set_prio", int'(ifa.overflow), 1);
    chk("t5_fill", int'(ifa.fill), 4);
    tick();
    ifa.ovf_clr = 1'b0;
    chk("t5_clr", int'(ifa.overflow), 0);

    // Full with simultaneous push and pop
    ifa.sum_stb = 1'b1; ifa.sum_in = 8'hAA; ifa.out_ready = 1'b1; tick();
    ifa.sum_stb = 1'b0; ifa.out_ready = 1'b0;
    chk("t4_fill", int'(ifa.fill), 4);
    chk("t4_ovf", int'(ifa.overflow), 0);
    ifa.out_ready = 1'b1;
    chk("t4_rd0", int'(ifa.out_data), 2); tick();
    chk("t4_rd1", int'(ifa.out_data), 3); tick();
    chk("t4_rd2", int'(ifa.out_data), 4); tick();
    chk("t4_rd3", int'(ifa.out_data), 'hAA); tick();
    ifa.out_ready = 1'b0;
    chk("t4_valid_end", int'(ifa.out_valid), 0);
    chk("t4_fill_end", int'(ifa.fill), 0);

    // Reset mid-stream discards contents, overriding a concurrent strobe
    ifa.sum_stb = 1'b1;
    ifa.sum_in = 8'h11; tick();
    ifa.sum_in = 8'h22; tick();
    ifa.sum_in = 8'h33; tick();
    chk("t6_fill3", int'(ifa.fill), 3);
    rst = 1'b1; ifa.sum_in = 8'h44; tick();
    rst = 1'b0; ifa.sum_stb = 1'b0;
    chk("t6_fill", int'(ifa.fill), 0);
    chk("t6_valid", int'(ifa.out_valid), 0);
    chk("t6_data", int'(ifa.out_data), 0);
    ifa.sum_stb = 1'b1; ifa.sum_in = 8'h55; tick();
    ifa.sum_stb = 1'b0;
    chk("t6_first", int'(ifa.out_data), 'h55);
    chk("t6_fill1", int'(ifa.fill), 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
